// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported data memory between the core load/store path and
//   an auxiliary requester (loader / debug port). One access is issued per
//   cycle. The core has priority. The aux port wins once it has waited
//   STARVE_LIM cycles. Read data returns one cycle after issue, and only the
//   port that issued the read sees rvalid.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   core_req/we/addr/wdata     core request; core_gnt issues it this cycle
//   core_stall                 core_req & ~core_gnt
//   core_rvalid/core_rdata     core read response (cycle after the grant)
//   aux_req/we/addr/wdata      aux request; aux_gnt issues it this cycle
//   aux_rvalid/aux_rdata       aux read response (cycle after the grant)
//   mem_wr/mem_rd/mem_addr/mem_wr_data   memory command (zero-latency issue)
//   mem_rd_data                memory read data, valid one cycle after mem_rd
module dmem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic {
    TAG_CORE = 1'b0,
    TAG_AUX  = 1'b1
  } rd_tag_e;

  localparam logic [3:0] WAIT_LIM = 4'(STARVE_LIM);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  rd_tag_e    rd_tag_q, rd_tag_d;
  logic       aux_starved;

  // Grant decision. Grants are masked during reset so nothing reaches memory.
  always_comb begin
    aux_starved = (wait_cnt_q == WAIT_LIM);
    core_gnt    = ~reset & core_req & ~(aux_req & aux_starved);
    aux_gnt     = ~reset & aux_req & (~core_req | aux_starved);
    core_stall  = ~reset & core_req & ~core_gnt;
  end

  // Memory command mux. With no grant the bus is driven to zero.
  always_comb begin
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (core_gnt) begin
      mem_wr      = core_we;
      mem_rd      = ~core_we;
      mem_addr    = core_addr;
      mem_wr_data = core_wdata;
    end else if (aux_gnt) begin
      mem_wr      = aux_we;
      mem_rd      = ~aux_we;
      mem_addr    = aux_addr;
      mem_wr_data = aux_wdata;
    end
  end

  // Next state: starvation counter and read-response tracking.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!aux_req || aux_gnt) begin
      wait_cnt_d = '0;
    end else if (!aux_starved) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rd_pend_d = mem_rd;
    rd_tag_d  = rd_tag_q;
    if (mem_rd) begin
      rd_tag_d = aux_gnt ? TAG_AUX : TAG_CORE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= TAG_CORE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  // Read response. Both ports see the memory data; only the tagged port's
  // rvalid is high. The async reset clears rd_pend_q, so a read in flight
  // at reset never returns.
  assign core_rvalid = rd_pend_q & (rd_tag_q == TAG_CORE);
  assign aux_rvalid  = rd_pend_q & (rd_tag_q == TAG_AUX);
  assign core_rdata  = mem_rd_data;
  assign aux_rdata   = mem_rd_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, aux_req, aux_we;
  logic [8:0]  core_addr, aux_addr;
  logic [31:0] core_wdata, aux_wdata;
  logic        core_gnt, core_stall, core_rvalid, aux_gnt, aux_rvalid;
  logic [31:0] core_rdata, aux_rdata;
  logic        mem_wr, mem_rd;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    bit          tag;   // 0 = core, 1 = aux
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ram    [512];
  logic [31:0] shadow [512];

  dmem_arbiter #(
    .DATA_W(32),
    .ADDR_W(9),
    .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
    .aux_rdata(aux_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-ported memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= ram[mem_addr];
  end

  // Scoreboard: each expected read response is due in a specific cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        exp_t e;
        logic [31:0] rd;
        e = exp_q.pop_front();
        rd = e.tag ? aux_rdata : core_rdata;
        vectors++;
        if (core_rvalid !== !e.tag || aux_rvalid !== e.tag || rd !== e.data) begin
          errors++;
          $display("FAIL read_response: core_rvalid=%b aux_rvalid=%b rdata=%h, required tag=%0d data=%h",
                   core_rvalid, aux_rvalid, rd, e.tag, e.data);
        end
      end else if (core_rvalid !== 1'b0 || aux_rvalid !== 1'b0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_rvalid: core_rvalid=%b aux_rvalid=%b, required 0 0",
                 core_rvalid, aux_rvalid);
      end
    end
  end

  task automatic step(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                      input logic ar, input logic aw, input logic [8:0] aa, input logic [31:0] ad);
    @(posedge clk);
    #1;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    aux_req  = ar; aux_we  = aw; aux_addr  = aa; aux_wdata  = ad;
    @(negedge clk);
  endtask

  task automatic push_read(input bit tag, input logic [8:0] addr);
    exp_t e;
    e.tag  = tag;
    e.data = shadow[addr];
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 9'h000, '0, 1'b1, 1'b0, 9'h001, '0);
      vectors++;
      if ({core_gnt, aux_gnt, core_rvalid, aux_rvalid, mem_wr, mem_rd, core_stall} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs: gnt/rvalid/mem/stall=%b, required 0000000",
                 {core_gnt, aux_gnt, core_rvalid, aux_rvalid, mem_wr, mem_rd, core_stall});
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_gnt !== 1'b1 || aux_gnt !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h000) begin
      errors++;
      $display("FAIL reset_release_grant: core_gnt=%b aux_gnt=%b mem_rd=%b addr=%h, required 1 0 1 000",
               core_gnt, aux_gnt, mem_rd, mem_addr);
    end
    push_read(1'b0, 9'h000);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_core_rw();
    step(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (core_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_rd !== 1'b0 ||
        mem_addr !== 9'h010 || mem_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL core_write: gnt=%b wr=%b rd=%b addr=%h wdata=%h, required 1 1 0 010 deadbeef",
               core_gnt, mem_wr, mem_rd, mem_addr, mem_wr_data);
    end
    shadow[9'h010] = 32'hDEADBEEF;
    step(1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (core_gnt !== 1'b1 || mem_wr !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h010) begin
      errors++;
      $display("FAIL core_read_issue: gnt=%b wr=%b rd=%b addr=%h, required 1 0 1 010",
               core_gnt, mem_wr, mem_rd, mem_addr);
    end
    push_read(1'b0, 9'h010);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (core_rvalid !== 1'b1 || aux_rvalid !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL core_read_data: rvalid=%b aux_rvalid=%b rdata=%h, required 1 0 deadbeef",
               core_rvalid, aux_rvalid, core_rdata);
    end
    vectors++;
    if ({mem_wr, mem_rd, core_gnt, aux_gnt} !== 4'b0 || mem_addr !== 9'h0 || mem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL idle_bus: wr/rd/gnt=%b addr=%h wdata=%h, required 0000 000 00000000",
               {mem_wr, mem_rd, core_gnt, aux_gnt}, mem_addr, mem_wr_data);
    end
  endtask

  task automatic test_contention();
    int ci = 0;
    int ak = 0;
    for (int i = 0; i < 2 * (LIM + 1); i++) begin
      logic [8:0]  ca, aa;
      logic [31:0] ad;
      bit          exp_a;
      ca = 9'(9'h040 + ci);
      aa = 9'(9'h1A0 + ak);
      ad = 32'hA000_0000 + 32'(ak);
      exp_a = ((i % (LIM + 1)) == LIM);
      step(1'b1, 1'b0, ca, '0, 1'b1, 1'b1, aa, ad);
      vectors++;
      if (core_gnt !== !exp_a || aux_gnt !== exp_a || core_stall !== exp_a ||
          mem_wr !== exp_a || mem_rd !== !exp_a) begin
        errors++;
        $display("FAIL contention cycle %0d: core_gnt=%b aux_gnt=%b stall=%b wr=%b rd=%b, required aux_win=%0d",
                 i, core_gnt, aux_gnt, core_stall, mem_wr, mem_rd, exp_a);
      end
      if (exp_a) begin
        shadow[aa] = ad;
        ak++;
      end else begin
        push_read(1'b0, ca);
        ci++;
      end
    end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_aux_top();
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h1FF, '0);
    vectors++;
    if (aux_gnt !== 1'b1 || core_gnt !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h1FF) begin
      errors++;
      $display("FAIL aux_top_issue: aux_gnt=%b core_gnt=%b rd=%b addr=%h, required 1 0 1 1ff",
               aux_gnt, core_gnt, mem_rd, mem_addr);
    end
    push_read(1'b1, 9'h1FF);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (aux_rvalid !== 1'b1 || core_rvalid !== 1'b0 || aux_rdata !== shadow[9'h1FF]) begin
      errors++;
      $display("FAIL aux_top_data: aux_rvalid=%b core_rvalid=%b rdata=%h, required 1 0 %h",
               aux_rvalid, core_rvalid, aux_rdata, shadow[9'h1FF]);
    end
  endtask

  task automatic test_aux_drop();
    // Two losses, one cycle with aux_req low, then LIM more losses before the win
    for (int i = 0; i < 3 + LIM + 1; i++) begin
      bit ar, exp_a;
      logic [8:0] ca;
      ar    = (i != 2);
      exp_a = (i == 3 + LIM);
      ca    = 9'(9'h080 + i);
      step(1'b1, 1'b0, ca, '0, ar, 1'b0, 9'h020, '0);
      vectors++;
      if (core_gnt !== !exp_a || aux_gnt !== exp_a) begin
        errors++;
        $display("FAIL aux_drop cycle %0d: core_gnt=%b aux_gnt=%b, required %b %b",
                 i, core_gnt, aux_gnt, !exp_a, exp_a);
      end
      if (exp_a) push_read(1'b1, 9'h020);
      else       push_read(1'b0, ca);
    end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 9'h1A0, '0, 1'b0, 1'b0, '0, '0);
    push_read(1'b0, 9'h1A0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h010, '0);
    vectors++;
    if (aux_gnt !== 1'b1 || core_rvalid !== 1'b1 || core_rdata !== 32'hA000_0000) begin
      errors++;
      $display("FAIL b2b_second: aux_gnt=%b core_rvalid=%b rdata=%h, required 1 1 a0000000",
               aux_gnt, core_rvalid, core_rdata);
    end
    push_read(1'b1, 9'h010);
    step(1'b1, 1'b0, 9'h1A1, '0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (core_gnt !== 1'b1 || aux_rvalid !== 1'b1 || core_rvalid !== 1'b0 || aux_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_third: core_gnt=%b aux_rvalid=%b core_rvalid=%b rdata=%h, required 1 1 0 deadbeef",
               core_gnt, aux_rvalid, core_rvalid, aux_rdata);
    end
    push_read(1'b0, 9'h1A1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 1'b0, 9'h030, '0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (core_gnt !== 1'b1 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL midread_issue: core_gnt=%b rd=%b, required 1 1", core_gnt, mem_rd);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    core_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_rvalid !== 1'b0 || aux_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midread_reset: core_rvalid=%b aux_rvalid=%b, required 0 0", core_rvalid, aux_rvalid);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_rvalid !== 1'b0 || aux_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midread_release: core_rvalid=%b aux_rvalid=%b, required 0 0", core_rvalid, aux_rvalid);
    end
    step(1'b1, 1'b0, 9'h011, '0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (core_gnt !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 9'h011) begin
      errors++;
      $display("FAIL midread_next: core_gnt=%b rd=%b addr=%h, required 1 1 011", core_gnt, mem_rd, mem_addr);
    end
    push_read(1'b0, 9'h011);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    aux_req  = 1'b0; aux_we  = 1'b0; aux_addr  = '0; aux_wdata  = '0;
    for (int i = 0; i < 512; i++) begin
      ram[i]    = 32'h5A00_0000 | 32'(i);
      shadow[i] = 32'h5A00_0000 | 32'(i);
    end

    test_reset();
    test_core_rw();
    test_contention();
    test_aux_top();
    test_aux_drop();
    test_back_to_back();
    test_reset_mid_read();

    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the RISC-V core's load/store path and an auxiliary requester (program loader / debug port). It sits between the datapath's memory request signals and the data memory. It grants one access per cycle with core priority and a starvation guard for the auxiliary port. It also returns read data with a tagged one-cycle-latency valid, and stalls the core when it loses arbitration.

## Interface
- DATA_W, 32, data width of both ports and memory
- ADDR_W, 9, word address width (matches 9-bit dmem address)
- STARVE_LIM, 4, cycles the aux port may wait before it wins over the core; legal range 1..15

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core requests an access this cycle
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access issued this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- aux_req, aux_we, aux_addr, aux_wdata  in  1/1/ADDR_W/DATA_W  same meaning for the aux port
- aux_gnt, aux_rvalid, aux_rdata  out  1/1/DATA_W  same meaning for the aux port
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid one cycle after mem_rd

## Operation
- Grant decision is combinational from current requests and registered state; at most one of core_gnt/aux_gnt is high per cycle.
- Priority: if only one port requests, that port is granted. If both request, the core wins unless wait_cnt == STARVE_LIM, in which case aux wins.
- wait_cnt register (4 bits): +1 on each cycle with aux_req & ~aux_gnt, saturating at STARVE_LIM. It clears to 0 on aux_gnt and on any cycle with aux_req low.
- Granted port's we/addr/wdata are muxed onto mem_*: mem_wr = gnt & we, mem_rd = gnt & ~we. With no grant, mem_wr = mem_rd = 0 and mem_addr/mem_wr_data = 0.
- Read tracking: rd_pend (1 bit) and rd_tag (0 = core, 1 = aux) are registered on the cycle of a granted read. The next cycle asserts the tagged port's rvalid.
- core_rdata and aux_rdata both equal mem_rd_data. Only the tagged port's rvalid is high.
- Writes produce no response beyond gnt.
- Requester rule: req/we/addr/wdata are held stable until gnt. Dropping req before gnt is legal and cancels the request; it also clears wait_cnt if aux.

## Timing
- Cycle N: req & gnt → memory command on mem_* in cycle N (zero-latency issue).
- Cycle N+1: for a read, <port>_rvalid = 1 and <port>_rdata = mem_rd_data. A new grant in N+1 is allowed (back-to-back throughput 1/cycle).
- core_stall is combinational, high in every cycle core waits.
- Reset values (async, immediate): wait_cnt = 0, rd_pend = 0, rd_tag = 0. While reset is high, all gnt, rvalid, stall, mem_wr and mem_rd are 0.
- Reset mid-read: pending rvalid is dropped and never issued after reset release.
- Continuous contention: aux is guaranteed a grant within STARVE_LIM+1 cycles of raising aux_req.
- Simultaneous read grant in N and read grant in N+1: rvalid in N+1 and N+2 are each tagged by their own grant cycle.

## Test plan
- Reset held 3 cycles with both reqs high → all gnt/rvalid/mem_wr/mem_rd = 0; after release, first cycle grants core.
- Core write addr 0x010, data 0xDEADBEEF, then core read 0x010 → core_gnt in both cycles, mem_wr then mem_rd; core_rvalid the next cycle with core_rdata = 0xDEADBEEF, aux_rvalid = 0.
- Both reqs continuously high, STARVE_LIM = 4 → core granted 4 cycles, aux granted on 5th, core_stall = 1 that cycle, then the pattern repeats.
- Aux alone reads 0x1FF (wrap-to-top address) → aux_gnt same cycle, aux_rvalid next cycle, wait_cnt stays 0.
- Aux waits 2 cycles, drops req for 1 cycle, re-requests under contention → wait_cnt restarts from 0, aux granted only after 4 more losses.
- Reset asserted in the cycle after a granted core read → core_rvalid never asserts; after release, rd_pend = 0 and the next grant behaves normally.
